// File: rtl/d_flip_flop_pkg.sv
// Shared constants and parameter sanity helper for the D register family.
package d_flip_flop_pkg;

  localparam int DFF_MIN_WIDTH  = 1;
  localparam int DFF_MIN_STAGES = 1;

  // True when a width/depth pair describes a buildable register chain.
  function automatic bit dffParamsValid(input int width, input int stages);
    return (width >= DFF_MIN_WIDTH) && (stages >= DFF_MIN_STAGES);
  endfunction

endpackage : d_flip_flop_pkg

// File: rtl/d_flip_flop_dff_stage.sv
// One WIDTH-bit positive-edge register with synchronous reset to RESET_VALUE.
module dff_stage #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_q;

  // Capture d_i on the rising edge; reset wins over data on the same edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule : dff_stage

// File: rtl/d_flip_flop.sv
// Parameterisable D register: a chain of STAGES dff_stage cells, q_o taken
// straight from the last flop so there is no combinational path to the output.
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Refuse to elaborate a chain with no bits or no stages.
  if (!dffParamsValid(WIDTH, STAGES)) begin : gParamCheck
    $fatal(1, "d_flip_flop: WIDTH (%0d) and STAGES (%0d) must both be >= 1", WIDTH, STAGES);
  end

  // w_chain[0] is the input, w_chain[k] the output of stage k-1.
  logic [WIDTH-1:0] w_chain [0:STAGES];

  assign w_chain[0] = d_i;

  // Cascade the stages output-to-input; every stage shares clock and reset.
  for (genvar g = 0; g < STAGES; g++) begin : gStage
    dff_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) uStage (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .d_i     (w_chain[g]),
      .q_o     (w_chain[g+1])
    );
  end

  assign q_o = w_chain[STAGES];

endmodule : d_flip_flop

// File: tb/tb_d_flip_flop.sv
// Bench for d_flip_flop: three instances (1-bit/1-stage, 8-bit/3-stage with
// zero reset, 8-bit/3-stage with 8'hFF reset) sharing clock and reset.
module tb_d_flip_flop;

  typedef struct {
    logic rst;
    logic d;
    logic expQ;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       d1;
  logic [7:0] d2;
  logic [7:0] d3;
  logic       q1;
  logic [7:0] q2;
  logic [7:0] q3;

  int compareCount = 0;
  int failCount    = 0;
  int edgeCount    = 0;
  int firstReset   = 0;

  logic [7:0] dHist [3][0:4095];
  bit         resetHist [0:4095];

  d_flip_flop #(.WIDTH(1), .STAGES(1), .RESET_VALUE(1'b0)) uDut1 (
    .clk_i(clk), .reset_i(reset), .d_i(d1), .q_o(q1));

  d_flip_flop #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'h00)) uDut2 (
    .clk_i(clk), .reset_i(reset), .d_i(d2), .q_o(q2));

  d_flip_flop #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hFF)) uDut3 (
    .clk_i(clk), .reset_i(reset), .d_i(d3), .q_o(q3));

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s (edge %0d): got %h expected %h", name, edgeCount, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v1, input logic [7:0] v2, input logic [7:0] v3);
    reset = r;
    d1    = v1;
    d2    = v2;
    d3    = v3;
  endtask

  // Reference: after edge n, q is RV if any reset edge lies in the last S
  // edges, otherwise the input sampled S-1 edges earlier.
  function automatic logic [7:0] modelQ(input int idx, input int n, input int s, input logic [7:0] rv);
    for (int k = n - s + 1; k <= n; k++) begin
      if (resetHist[k]) return rv;
    end
    return dHist[idx][n - s + 1];
  endfunction

  // Advance one rising edge, log the sampled inputs, compare all DUTs 1 unit later.
  task automatic stepCycle();
    @(posedge clk);
    edgeCount++;
    resetHist[edgeCount] = reset;
    dHist[0][edgeCount]  = {7'b0, d1};
    dHist[1][edgeCount]  = d2;
    dHist[2][edgeCount]  = d3;
    if (reset && firstReset == 0) firstReset = edgeCount;
    #1;
    if (firstReset != 0) begin
      checkOutput("model q1", {7'b0, q1}, modelQ(0, edgeCount, 1, 8'h00));
      if (edgeCount - 2 >= 1) begin
        checkOutput("model q2", q2, modelQ(1, edgeCount, 3, 8'h00));
        checkOutput("model q3", q3, modelQ(2, edgeCount, 3, 8'hFF));
      end
    end
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = '{rst: 1'b1, d: 1'b1, expQ: 1'b0};
    vecs[1] = '{rst: 1'b1, d: 1'b0, expQ: 1'b0};
    vecs[2] = '{rst: 1'b0, d: 1'b1, expQ: 1'b1};
    vecs[3] = '{rst: 1'b0, d: 1'b0, expQ: 1'b0};
    vecs[4] = '{rst: 1'b0, d: 1'b1, expQ: 1'b1};
    vecs[5] = '{rst: 1'b0, d: 1'b1, expQ: 1'b1};
    vecs[6] = '{rst: 1'b1, d: 1'b1, expQ: 1'b0};
    vecs[7] = '{rst: 1'b0, d: 1'b0, expQ: 1'b0};
    vecs[8] = '{rst: 1'b0, d: 1'b1, expQ: 1'b1};

    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    #2;

    // Reset and basic tracking on the single-bit register.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].d, 8'h00, 8'h00);
      stepCycle();
      checkOutput($sformatf("table[%0d] q1", i), {7'b0, q1}, {7'b0, vecs[i].expQ});
      if (i == 0) begin
        checkOutput("reset q2", q2, 8'h00);
        checkOutput("reset q3", q3, 8'hFF);
      end
    end

    // Capture: data set 5 units ahead of the edge, then held until the next edge.
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    stepCycle();
    checkOutput("capture pre q1", {7'b0, q1}, 8'h00);
    #4 d1 = 1'b1;
    stepCycle();
    checkOutput("capture q1", {7'b0, q1}, 8'h01);
    d1 = 1'b0;
    #8;
    checkOutput("capture hold q1", {7'b0, q1}, 8'h01);

    // Glitch between edges is invisible.
    stepCycle();
    checkOutput("glitch pre q1", {7'b0, q1}, 8'h00);
    #2 d1 = 1'b1;
    #2 d1 = 1'b0;
    stepCycle();
    checkOutput("glitch q1", {7'b0, q1}, 8'h00);

    // Reset priority on an edge, then a reset pulse that misses every edge.
    applyStimulus(1'b1, 1'b1, 8'h00, 8'h00);
    stepCycle();
    checkOutput("reset prio q1", {7'b0, q1}, 8'h00);
    reset = 1'b0;
    stepCycle();
    checkOutput("post reset q1", {7'b0, q1}, 8'h01);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    stepCycle();
    checkOutput("reset pulse q1", {7'b0, q1}, 8'h01);

    // Three-stage latency: A5 for one edge appears exactly on the third edge.
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) stepCycle();
    d2 = 8'hA5;
    stepCycle();
    checkOutput("latency e1 q2", q2, 8'h00);
    d2 = 8'h00;
    stepCycle();
    checkOutput("latency e2 q2", q2, 8'h00);
    stepCycle();
    checkOutput("latency e3 q2", q2, 8'hA5);
    stepCycle();
    checkOutput("latency e4 q2", q2, 8'h00);

    // Reset mid-stream on the FF-reset chain: in-flight data dropped.
    d3 = 8'h11; stepCycle();
    d3 = 8'h22; stepCycle();
    d3 = 8'h33; stepCycle();
    checkOutput("stream q3", q3, 8'h11);
    reset = 1'b1; d3 = 8'h44;
    stepCycle();
    checkOutput("mid reset q3", q3, 8'hFF);
    reset = 1'b0; d3 = 8'h55;
    stepCycle();
    checkOutput("release e1 q3", q3, 8'hFF);
    d3 = 8'h66;
    stepCycle();
    checkOutput("release e2 q3", q3, 8'hFF);
    d3 = 8'h77;
    stepCycle();
    checkOutput("release e3 q3", q3, 8'h55);

    // Random traffic with occasional resets, checked by the model each edge.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), 1'($urandom), 8'($urandom), 8'($urandom));
      stepCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule : tb_d_flip_flop
